// File: rtl/sync_ram_if.sv
// Request/response bus for sync_ram: one request channel with a ready
// handshake and a fixed-latency read response channel, plus the clear status.
interface sync_ram_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with byte-enable writes, a fully pipelined
// fixed-latency read path and an optional zero-fill sequence after reset.
// While the zero-fill runs the request channel is closed (req_ready=0).
module sync_ram #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  sync_ram_if.slave bus
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic   RESET_BUSY  = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   clear_cnt_r;
  logic                    ready_r;
  logic                    busy_r;

  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    accept_s;
  logic                    rd_accept_s;
  logic                    wr_en_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic [NBYTES-1:0]       wr_be_s;

  // Stage i holds a response that becomes visible i+1 cycles after accept;
  // the last stage drives the response port directly.
  logic [READ_LATENCY-1:0] pipe_vld_r;
  logic [DATA_WIDTH-1:0]   pipe_dat_r [READ_LATENCY];

  assign accept_s    = bus.req_valid & ready_r;
  assign rd_accept_s = accept_s & ~bus.req_we;

  // Control FSM: walk the clear counter once, then stay open for requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RESET_STATE;
      clear_cnt_r <= '0;
      ready_r     <= 1'b0;
      busy_r      <= RESET_BUSY;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clear_cnt_r <= clear_cnt_r + ADDR_WIDTH'(1);
          if (clear_cnt_r == LAST_ADDR) begin
            // This edge writes the last word, so open the bus next cycle.
            state_r <= ST_RUN;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= RESET_STATE;
          clear_cnt_r <= '0;
          ready_r     <= 1'b0;
          busy_r      <= RESET_BUSY;
        end
      endcase
    end
  end

  // Write port select: the clear sequence owns the port until it finishes.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = bus.req_addr;
    wr_data_s = bus.req_wdata;
    wr_be_s   = bus.req_be;
    if (state_r == ST_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clear_cnt_r;
      wr_data_s = '0;
      wr_be_s   = '1;
    end else begin
      wr_en_s   = accept_s & bus.req_we;
    end
  end

  // Memory array: byte-masked write, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be_s[b]) begin
          mem_r[wr_addr_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: capture the word at the accept edge, then shift; data
  // stages only load on valid so the output holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_dat_r[i] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= rd_accept_s;
      if (rd_accept_s) begin
        pipe_dat_r[0] <= mem_r[bus.req_addr];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        if (pipe_vld_r[i-1]) begin
          pipe_dat_r[i] <= pipe_dat_r[i-1];
        end
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = pipe_vld_r[READ_LATENCY-1];
  assign bus.rsp_rdata = pipe_dat_r[READ_LATENCY-1];

endmodule

// File: tb/tb_sync_ram.sv
// Directed testbench for sync_ram covering four parameter sets:
//   d0: defaults (8-bit addr/data, latency 1, clear on reset)
//   d1: 4-bit addr, 32-bit data, latency 3
//   d2: 4-bit addr, 8-bit data, latency 2 (reset mid-flight)
//   d3: 4-bit addr, 8-bit data, latency 1, no clear on reset
module tb_sync_ram;

  logic clk = 1'b0;
  logic rst0, rst1, rst2, rst3;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sync_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8))  if0 ();
  sync_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) if1 ();
  sync_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8))  if2 ();
  sync_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8))  if3 ();

  sync_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1), .CLEAR_ON_RESET(1))
    d0 (.clk(clk), .rst_n(rst0), .bus(if0));
  sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(3), .CLEAR_ON_RESET(1))
    d1 (.clk(clk), .rst_n(rst1), .bus(if1));
  sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(2), .CLEAR_ON_RESET(1))
    d2 (.clk(clk), .rst_n(rst2), .bus(if2));
  sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1), .CLEAR_ON_RESET(0))
    d3 (.clk(clk), .rst_n(rst3), .bus(if3));

  // ---------------- bus drivers (no checking) ----------------
  task automatic wr0(input logic [7:0] a, input logic [7:0] d, input logic be);
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = a;
    if0.req_wdata = d; if0.req_be = be;
    @(posedge clk); #1;
    if0.req_valid = 1'b0; if0.req_we = 1'b0;
  endtask

  task automatic rd0(input logic [7:0] a, output logic [7:0] d, output int lat);
    if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_addr = a;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    lat = 1;
    while (!if0.rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    d = if0.rsp_rdata;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    if1.req_valid = 1'b1; if1.req_we = 1'b1; if1.req_addr = a;
    if1.req_wdata = d; if1.req_be = be;
    @(posedge clk); #1;
    if1.req_valid = 1'b0; if1.req_we = 1'b0;
  endtask

  task automatic rd1(input logic [3:0] a, output logic [31:0] d, output int lat);
    if1.req_valid = 1'b1; if1.req_we = 1'b0; if1.req_addr = a;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    lat = 1;
    while (!if1.rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    d = if1.rsp_rdata;
  endtask

  task automatic wr2(input logic [3:0] a, input logic [7:0] d);
    if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = a;
    if2.req_wdata = d; if2.req_be = 1'b1;
    @(posedge clk); #1;
    if2.req_valid = 1'b0; if2.req_we = 1'b0;
  endtask

  task automatic rd2(input logic [3:0] a, output logic [7:0] d, output int lat);
    if2.req_valid = 1'b1; if2.req_we = 1'b0; if2.req_addr = a;
    @(posedge clk); #1;
    if2.req_valid = 1'b0;
    lat = 1;
    while (!if2.rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    d = if2.rsp_rdata;
  endtask

  task automatic wr3(input logic [3:0] a, input logic [7:0] d);
    if3.req_valid = 1'b1; if3.req_we = 1'b1; if3.req_addr = a;
    if3.req_wdata = d; if3.req_be = 1'b1;
    @(posedge clk); #1;
    if3.req_valid = 1'b0; if3.req_we = 1'b0;
  endtask

  task automatic rd3(input logic [3:0] a, output logic [7:0] d, output int lat);
    if3.req_valid = 1'b1; if3.req_we = 1'b0; if3.req_addr = a;
    @(posedge clk); #1;
    if3.req_valid = 1'b0;
    lat = 1;
    while (!if3.rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    d = if3.rsp_rdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if0.req_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", if0.req_ready); else passed++;
    checks++; if (if0.busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", if0.busy); else passed++;
    checks++; if (if0.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", if0.rsp_valid); else passed++;
    checks++; if (if0.rsp_rdata !== 8'h00) $display("FAIL reset_rsp_rdata: got %h expected 00", if0.rsp_rdata); else passed++;
    checks++; if (if3.busy !== 1'b0) $display("FAIL reset_noclear_busy: got %b expected 0", if3.busy); else passed++;
    checks++; if (if3.req_ready !== 1'b0) $display("FAIL reset_noclear_ready: got %b expected 0", if3.req_ready); else passed++;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
  endtask

  // Counts busy cycles after release while hammering the closed bus.
  task automatic test_clear();
    int   n   = 0;
    logic bad = 1'b0;
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = 8'h10;
    if0.req_wdata = 8'hEE; if0.req_be = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (if0.rsp_valid) bad = 1'b1;
      if0.req_we = ~if0.req_we;
    end while (if0.busy && n < 1000);
    if0.req_valid = 1'b0; if0.req_we = 1'b0;
    checks++; if (n !== 256) $display("FAIL clear_cycles: got %0d expected 256", n); else passed++;
    checks++; if (bad !== 1'b0) $display("FAIL clear_no_rsp: got rsp_valid during busy"); else passed++;
    checks++; if (if0.req_ready !== 1'b1) $display("FAIL clear_ready_after: got %b expected 1", if0.req_ready); else passed++;
  endtask

  task automatic test_clear_readback();
    logic [7:0] addrs [4] = '{8'h00, 8'h7F, 8'hFF, 8'h10};
    logic [7:0] d;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      rd0(addrs[i], d, lat);
      checks++; if (lat !== 1) $display("FAIL clear_rd_latency[%h]: got %0d expected 1", addrs[i], lat); else passed++;
      checks++; if (d !== 8'h00) $display("FAIL clear_rd_data[%h]: got %h expected 00", addrs[i], d); else passed++;
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    int         lat;
    wr0(8'h09, 8'h5A, 1'b1);
    checks++; if (if0.rsp_valid !== 1'b0) $display("FAIL write_no_rsp: got %b expected 0", if0.rsp_valid); else passed++;
    rd0(8'h09, d, lat);
    checks++; if (lat !== 1) $display("FAIL raw_latency: got %0d expected 1", lat); else passed++;
    checks++; if (d !== 8'h5A) $display("FAIL raw_data: got %h expected 5a", d); else passed++;
    @(posedge clk); #1;
    checks++; if (if0.rsp_valid !== 1'b0) $display("FAIL rsp_pulse: got %b expected 0", if0.rsp_valid); else passed++;
    checks++; if (if0.rsp_rdata !== 8'h5A) $display("FAIL rsp_hold: got %h expected 5a", if0.rsp_rdata); else passed++;
    wr0(8'h09, 8'hFF, 1'b0);
    rd0(8'h09, d, lat);
    checks++; if (d !== 8'h5A) $display("FAIL be0_noop: got %h expected 5a", d); else passed++;
    wr0(8'h09, 8'hA5, 1'b1);
    rd0(8'h09, d, lat);
    checks++; if (d !== 8'hA5) $display("FAIL overwrite: got %h expected a5", d); else passed++;
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    int          lat;
    checks++; if (if1.req_ready !== 1'b1) $display("FAIL be_ready: got %b expected 1", if1.req_ready); else passed++;
    wr1(4'h5, 32'hAABBCCDD, 4'b1111);
    wr1(4'h5, 32'h11223344, 4'b0101);
    rd1(4'h5, d, lat);
    checks++; if (lat !== 3) $display("FAIL be_latency: got %0d expected 3", lat); else passed++;
    checks++; if (d !== 32'hAA22CC44) $display("FAIL be_merge: got %h expected aa22cc44", d); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a <= 4; a++) wr1(4'(a), 32'h10 + 32'(a - 1), 4'b1111);
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4) begin
        if1.req_valid = 1'b1; if1.req_we = 1'b0; if1.req_addr = 4'(c);
      end else begin
        if1.req_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 3 && c <= 6) begin
        checks++; if (if1.rsp_valid !== 1'b1) $display("FAIL b2b_valid[c%0d]: got %b expected 1", c, if1.rsp_valid); else passed++;
        checks++; if (if1.rsp_rdata !== 32'h10 + 32'(c - 3)) $display("FAIL b2b_data[c%0d]: got %h expected %h", c, if1.rsp_rdata, 32'h10 + 32'(c - 3)); else passed++;
      end else begin
        checks++; if (if1.rsp_valid !== 1'b0) $display("FAIL b2b_idle[c%0d]: got %b expected 0", c, if1.rsp_valid); else passed++;
      end
    end
    checks++; if (if1.rsp_rdata !== 32'h13) $display("FAIL b2b_hold: got %h expected 13", if1.rsp_rdata); else passed++;
  endtask

  task automatic test_reset_midflight();
    logic [7:0] d;
    int         lat;
    int         n   = 0;
    logic       bad = 1'b0;
    wr2(4'h3, 8'h77);
    rd2(4'h3, d, lat);
    checks++; if (d !== 8'h77 || lat !== 2) $display("FAIL mf_pre_read: got %h lat %0d expected 77 lat 2", d, lat); else passed++;
    if2.req_valid = 1'b1; if2.req_we = 1'b0; if2.req_addr = 4'h3;
    @(posedge clk); #1;
    if2.req_valid = 1'b0;
    rst2 = 1'b0;
    #1;
    checks++; if (if2.rsp_valid !== 1'b0) $display("FAIL mf_rsp_valid: got %b expected 0", if2.rsp_valid); else passed++;
    checks++; if (if2.busy !== 1'b1 || if2.req_ready !== 1'b0) $display("FAIL mf_busy_ready: got %b/%b expected 1/0", if2.busy, if2.req_ready); else passed++;
    repeat (3) begin
      @(posedge clk); #1;
      if (if2.rsp_valid) bad = 1'b1;
    end
    rst2 = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (if2.rsp_valid) bad = 1'b1;
    end while (if2.busy && n < 200);
    checks++; if (bad !== 1'b0) $display("FAIL mf_discard: got rsp_valid after reset"); else passed++;
    checks++; if (n !== 16) $display("FAIL mf_clear_cycles: got %0d expected 16", n); else passed++;
    rd2(4'h3, d, lat);
    checks++; if (d !== 8'h00 || lat !== 2) $display("FAIL mf_cleared: got %h lat %0d expected 00 lat 2", d, lat); else passed++;
  endtask

  task automatic test_no_clear();
    logic [7:0] d;
    int         lat;
    checks++; if (if3.busy !== 1'b0 || if3.req_ready !== 1'b1) $display("FAIL nc_run: got busy %b ready %b expected 0/1", if3.busy, if3.req_ready); else passed++;
    wr3(4'h2, 8'h3C);
    rd3(4'h2, d, lat);
    checks++; if (d !== 8'h3C || lat !== 1) $display("FAIL nc_rw: got %h lat %0d expected 3c lat 1", d, lat); else passed++;
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = '0; if0.req_wdata = '0; if0.req_be = '0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = '0; if1.req_wdata = '0; if1.req_be = '0;
    if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_addr = '0; if2.req_wdata = '0; if2.req_be = '0;
    if3.req_valid = 1'b0; if3.req_we = 1'b0; if3.req_addr = '0; if3.req_wdata = '0; if3.req_be = '0;
    test_reset();
    test_clear();
    test_clear_readback();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_reset_midflight();
    test_no_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
